// File: rtl/mix_columns_seq_if.sv
// mix_columns_seq_if
// Block handshake bundle for the sequential MixColumns engine.
//   in_valid/in_ready   : input block handshake (valid/ready)
//   in_state            : 128-bit AES state, byte k = bits [8k:8k+7]
//   in_bypass           : per-block pass-through request
//   out_valid/out_ready : result handshake (valid/ready)
//   out_state           : 128-bit result, same ordering as in_state
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid && ready are both high. The engine's ready/valid outputs
// depend only on its state register and never on the partner's signals.
// Modports: master = block producer / result consumer, slave = engine.
interface mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] in_state;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_state;

  modport master (
    output in_valid, in_state, in_bypass, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, in_bypass, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/mix_columns_seq.sv
// mix_columns_seq
// Sequential AES forward MixColumns: accepts one 128-bit state, transforms
// one 32-bit column per clock, then holds the result until taken.
// A per-block bypass copies columns unchanged with identical latency.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   bus      : mix_columns_seq_if.slave (in/out valid/ready handshakes)
//   busy     : high while columns are being computed
//   dbgState : raw FSM state (0 IDLE, 1 BUSY, 2 DONE)
module mix_columns_seq (
  input  logic               clk,
  input  logic               rst_n,
  mix_columns_seq_if.slave   bus,
  output logic               busy,
  output logic [1:0]         dbgState
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  logic [1:0]   col;
  logic         bypassFlag;
  logic [0:127] workReg;
  logic [0:127] outReg;
  logic [0:31]  colIn;
  logic [0:31]  colOut;

  // GF(2^8) doubling with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [0:31] mixCol(input logic [0:31] a);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = a[0:7];
    a1 = a[8:15];
    a2 = a[16:23];
    a3 = a[24:31];
    b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  // Column col of the working register; {col,5'b0} is the bit offset 32*col.
  always_comb begin
    colIn  = workReg[{col, 5'b0} +: 32];
    colOut = bypassFlag ? colIn : mixCol(colIn);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      col        <= 2'd0;
      bypassFlag <= 1'b0;
      workReg    <= '0;
      outReg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            workReg    <= bus.in_state;
            bypassFlag <= bus.in_bypass;
            col        <= 2'd0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          outReg[{col, 5'b0} +: 32] <= colOut;
          col <= col + 2'd1;
          if (col == 2'd3) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status decoded from the state register only, so the reset value shows
  // up as soon as rst_n falls.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_state = outReg;
  assign busy          = (state == BUSY);
  assign dbgState      = state;

endmodule

// File: tb/tb_mix_columns_seq.sv
module tb_mix_columns_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [1:0] dbg_state;

  mix_columns_seq_if bus();

  mix_columns_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .dbgState (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [127:0] exp_q[$];

  localparam logic [0:127] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [0:127] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;

  // ---------------- reference helpers ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // InvMixColumns model of the decrypt side.
  function automatic logic [0:127] inv_mix(input logic [0:127] s);
    logic [0:127] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      r[32*c +: 8]    = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
      r[32*c+8 +: 8]  = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
      r[32*c+16 +: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
      r[32*c+24 +: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
    end
    return r;
  endfunction

  function automatic logic [0:127] rand_state();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- driver tasks ----------------
  // Presents one block and returns #1 after the accept edge (E0).
  task automatic drive_block(input logic [0:127] s, input logic byp);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_state  = s;
    bus.in_bypass = byp;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.in_state  = rand_state();
    bus.in_bypass = $urandom_range(0, 1);
  endtask

  // Waits for out_valid, counting edges after E0 and cycles with busy high.
  task automatic collect(output logic [0:127] got, output int lat,
                         output int busy_cnt, output bit timeout);
    lat      = 0;
    busy_cnt = busy ? 1 : 0;
    timeout  = 1'b1;
    got      = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busy_cnt++;
      if (bus.out_valid) begin
        got     = bus.out_state;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.in_bypass = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b need 1 0 0",
               bus.in_ready, bus.out_valid, busy);
    end
    total++;
    if (bus.out_state !== 128'h0) begin
      bad++;
      $display("FAIL reset_out_state: got %h need 0", bus.out_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fips();
    logic [0:127] got;
    logic [127:0] exp;
    int lat, bc;
    bit to;
    bus.out_ready = 1'b1;
    exp_q.push_back(FIPS_OUT);
    drive_block(FIPS_IN, 1'b0);
    collect(got, lat, bc, to);
    exp = exp_q.pop_front();
    total++;
    if (to) begin
      bad++;
      $display("FAIL fips_timeout: out_valid never rose");
    end
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL fips_data: got %h need %h", got, exp);
    end
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL fips_latency: got %0d need 4", lat);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL fips_one_cycle: out_valid=%b in_ready=%b need 0 1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_columns();
    logic [0:127] got;
    logic [0:127] exp;
    int lat, bc;
    bit to;
    bus.out_ready = 1'b1;
    exp_q.push_back({32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6});
    drive_block({32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6}, 1'b0);
    collect(got, lat, bc, to);
    exp = exp_q.pop_front();
    total++;
    if (to) begin
      bad++;
      $display("FAIL columns_timeout: out_valid never rose");
    end
    for (int c = 0; c < 4; c++) begin
      total++;
      if (got[32*c +: 32] !== exp[32*c +: 32]) begin
        bad++;
        $display("FAIL column_%0d: got %h need %h", c, got[32*c +: 32], exp[32*c +: 32]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_bypass();
    logic [0:127] got;
    logic [127:0] exp;
    int lat, bc;
    bit to;
    bus.out_ready = 1'b1;
    exp_q.push_back(FIPS_IN);
    drive_block(FIPS_IN, 1'b1);
    collect(got, lat, bc, to);
    exp = exp_q.pop_front();
    total++;
    if (to || got !== exp) begin
      bad++;
      $display("FAIL bypass_data: got %h need %h (timeout=%0b)", got, exp, to);
    end
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL bypass_latency: got %0d need 4", lat);
    end
    total++;
    if (bc !== 4) begin
      bad++;
      $display("FAIL bypass_busy_cycles: got %0d need 4", bc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [0:127] got;
    logic [127:0] exp;
    int lat, bc;
    bit to;
    bit stable_ok;
    bus.out_ready = 1'b0;
    exp_q.push_back(FIPS_OUT);
    drive_block(FIPS_IN, 1'b0);
    collect(got, lat, bc, to);
    exp = exp_q.pop_front();
    total++;
    if (to || got !== exp) begin
      bad++;
      $display("FAIL stall_data: got %h need %h (timeout=%0b)", got, exp, to);
    end
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_state  = rand_state();
      bus.in_bypass = $urandom_range(0, 1);
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b1 || bus.out_state !== exp || bus.in_ready !== 1'b0)
        stable_ok = 1'b0;
    end
    bus.in_valid = 1'b0;
    total++;
    if (!stable_ok) begin
      bad++;
      $display("FAIL stall_hold: out_valid=%b in_ready=%b out_state=%h need 1 0 %h",
               bus.out_valid, bus.in_ready, bus.out_state, exp);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_release: in_ready=%b out_valid=%b need 1 0",
               bus.in_ready, bus.out_valid);
    end
    // next block after the stall
    exp_q.push_back(128'h8e4da1bc9fdc589d01010101c6c6c6c6);
    drive_block(128'hdb135345f20a225c01010101c6c6c6c6, 1'b0);
    collect(got, lat, bc, to);
    exp = exp_q.pop_front();
    total++;
    if (to || got !== exp) begin
      bad++;
      $display("FAIL after_stall: got %h need %h (timeout=%0b)", got, exp, to);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic [0:127] got;
    logic [127:0] exp;
    int lat, bc;
    bit to;
    bus.out_ready = 1'b1;
    drive_block(FIPS_IN, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_flags: out_valid=%b busy=%b in_ready=%b need 0 0 1",
               bus.out_valid, busy, bus.in_ready);
    end
    total++;
    if (bus.out_state !== 128'h0) begin
      bad++;
      $display("FAIL midreset_out_state: got %h need 0", bus.out_state);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(FIPS_OUT);
    drive_block(FIPS_IN, 1'b0);
    collect(got, lat, bc, to);
    exp = exp_q.pop_front();
    total++;
    if (to || got !== exp || lat !== 4) begin
      bad++;
      $display("FAIL after_midreset: got %h lat %0d need %h lat 4", got, lat, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_cascade();
    logic [0:127] s;
    logic [0:127] got;
    logic [0:127] rec;
    logic [127:0] exp;
    int lat, bc;
    bit to;
    int fails;
    fails = 0;
    for (int n = 0; n < 1000; n++) begin
      s = rand_state();
      exp_q.push_back(s);
      bus.out_ready = $urandom_range(0, 1);
      drive_block(s, 1'b0);
      collect(got, lat, bc, to);
      exp = exp_q.pop_front();
      rec = inv_mix(got);
      total++;
      if (to || rec !== exp) begin
        bad++;
        fails++;
        if (fails < 5)
          $display("FAIL cascade_%0d: recovered %h need %h (timeout=%0b)", n, rec, exp, to);
      end
      if (bus.out_ready == 1'b0) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fips();
    test_columns();
    test_bypass();
    test_backpressure();
    test_reset_mid();
    test_cascade();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_empty: %0d left need 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
